// File: rtl/io_cond_pkg.sv
// Shared constants for the board input conditioner and the data memory decode
// that maps its outputs onto the memory-mapped input bytes.
package io_cond_pkg;

    localparam int N_SW  = 16;
    localparam int N_BTN = 5;

    localparam int SAMPLE_DIV_DEF   = 100000;
    localparam int STABLE_TICKS_DEF = 10;

    localparam logic [7:0] IO_SW_HI = 8'h4E;
    localparam logic [7:0] IO_SW_LO = 8'h4F;
    localparam logic [7:0] IO_BTNS  = 8'h50;

    typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer, tick-counted debouncer and rise detect.
// level changes after STABLE_TICKS consecutive mismatching ticks; no backpressure.
module debounce_bit
    import io_cond_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise
);

    localparam int              CW       = $clog2(STABLE_TICKS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          meta_q;
    logic          s_q;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized input agrees with stable restarts the run.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s_q == stable_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q   <= 1'b0;
            s_q      <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw;
            s_q      <= meta_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign rise  = stable_q & ~prev_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces 16 switches and 5 buttons; emits press pulses and sticky press flags.
// Levels settle 2 + ((STABLE_TICKS-1)*SAMPLE_DIV+1 .. STABLE_TICKS*SAMPLE_DIV) cycles after a raw edge.
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int SAMPLE_DIV   = SAMPLE_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SW-1:0]  SW_RAW,
    input  logic [N_BTN-1:0] BTNS_RAW,
    input  logic [N_BTN-1:0] CLR_STICKY,
    output logic [N_SW-1:0]  SW,
    output logic [N_BTN-1:0] BTNS,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_STICKY,
    output logic             TICK
);

    localparam int            PW        = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0] PDIV_LAST = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0]   pdiv_q, pdiv_d;
    logic [N_SW-1:0] sw_rise_unused;
    btn_vec_t        btn_rise;
    btn_vec_t        press_q;
    btn_vec_t        sticky_q, sticky_d;

    assign TICK   = (pdiv_q == PDIV_LAST);
    assign pdiv_d = TICK ? '0 : pdiv_q + 1'b1;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
            .CLK   (CLK),
            .RST_N (RST_N),
            .raw   (SW_RAW[i]),
            .tick  (TICK),
            .level (SW[i]),
            .rise  (sw_rise_unused[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
            .CLK   (CLK),
            .RST_N (RST_N),
            .raw   (BTNS_RAW[i]),
            .tick  (TICK),
            .level (BTNS[i]),
            .rise  (btn_rise[i])
        );
    end

    // A press landing in the same cycle as its clear keeps the flag set.
    assign sticky_d = (sticky_q & ~CLR_STICKY) | press_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pdiv_q   <= '0;
            press_q  <= '0;
            sticky_q <= '0;
        end else begin
            pdiv_q   <= pdiv_d;
            press_q  <= btn_rise;
            sticky_q <= sticky_d;
        end
    end

    assign BTN_PRESS  = press_q;
    assign BTN_STICKY = sticky_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with SAMPLE_DIV=4, STABLE_TICKS=3: directed
// scenarios with literal expectations plus random stimulus against a reference model.
module tb_io_input_conditioner;

    localparam int DIV = 4;
    localparam int ST  = 3;

    logic        CLK        = 1'b0;
    logic        RST_N      = 1'b0;
    logic [15:0] SW_RAW     = '0;
    logic [4:0]  BTNS_RAW   = '0;
    logic [4:0]  CLR_STICKY = '0;
    logic [15:0] SW;
    logic [4:0]  BTNS;
    logic [4:0]  BTN_PRESS;
    logic [4:0]  BTN_STICKY;
    logic        TICK;

    int total = 0;
    int bad   = 0;

    io_input_conditioner #(.SAMPLE_DIV(DIV), .STABLE_TICKS(ST)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SW_RAW     (SW_RAW),
        .BTNS_RAW   (BTNS_RAW),
        .CLR_STICKY (CLR_STICKY),
        .SW         (SW),
        .BTNS       (BTNS),
        .BTN_PRESS  (BTN_PRESS),
        .BTN_STICKY (BTN_STICKY),
        .TICK       (TICK)
    );

    always #5 CLK = ~CLK;

    // Reference model: m_n counts edges since reset, so the tick is pure arithmetic.
    // m_run[i] is how many consecutive sample ticks bit i has disagreed with its level.
    int          m_n;
    logic [20:0] m_sy1, m_sy2, m_lvl;
    int          m_run [21];
    logic [4:0]  m_prev, m_press, m_sticky;
    logic        m_t;

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            m_n = 0; m_sy1 = '0; m_sy2 = '0; m_lvl = '0;
            m_prev = '0; m_press = '0; m_sticky = '0;
            for (int i = 0; i < 21; i++) m_run[i] = 0;
        end else begin
            m_t      = ((m_n % DIV) == DIV - 1);
            m_sticky = (m_sticky & ~CLR_STICKY) | m_press;
            m_press  = m_lvl[20:16] & ~m_prev;
            m_prev   = m_lvl[20:16];
            for (int i = 0; i < 21; i++) begin
                if (m_sy2[i] == m_lvl[i]) begin
                    m_run[i] = 0;
                end else if (m_t) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == ST) begin
                        m_lvl[i] = m_sy2[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_sy2 = m_sy1;
            m_sy1 = {BTNS_RAW, SW_RAW};
            m_n   = m_n + 1;
        end
    end

    task automatic compare_all();
        logic [31:0] act, exp;
        logic        tk;
        tk  = ((m_n % DIV) == DIV - 1);
        act = {SW, BTNS, BTN_PRESS, BTN_STICKY, TICK};
        exp = {m_lvl[15:0], m_lvl[20:16], m_press, m_sticky, tk};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp);
        end
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Compare at the falling edge, then return 2 time units after the next rising edge.
    task automatic cyc();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        SW_RAW = '0; BTNS_RAW = '0; CLR_STICKY = '0;
        RST_N = 1'b0;
        repeat (2) cyc();
        RST_N = 1'b1;
        repeat (3) cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int k, np, np2, hold;

        // Reset with switches held high, a mid-count reset pulse, then acceptance.
        SW_RAW = 16'hFFFF;
        repeat (5) cyc();
        chk_eq("rst_outputs", {SW, BTNS, BTN_PRESS, BTN_STICKY, TICK}, 32'h0);
        RST_N = 1'b1;
        repeat (4) cyc();
        RST_N = 1'b0;
        cyc();
        chk_eq("rst_mid_count", {16'h0, SW}, 32'h0);
        RST_N = 1'b1;
        k = 0;
        do begin cyc(); k++; end while (SW !== 16'hFFFF && k < 20);
        chk_rng("s1_sw_latency", k, 11, 14);

        // Clean press on button 2.
        BTNS_RAW = 5'b00100;
        k = 0;
        do begin cyc(); k++; end while (BTNS !== 5'b00100 && k < 20);
        chk_rng("s2_btn_latency", k, 11, 14);
        cyc();
        chk_eq("s2_press_on", {27'h0, BTN_PRESS}, 32'h4);
        cyc();
        chk_eq("s2_press_off_sticky", {22'h0, BTN_PRESS, BTN_STICKY}, 32'h4);
        repeat (6) cyc();
        chk_eq("s2_sticky_hold", {27'h0, BTN_STICKY}, 32'h4);

        // Six-cycle glitch on switch 0 is never accepted.
        do_reset();
        repeat ($urandom_range(0, 3)) cyc();
        SW_RAW[0] = 1'b1;
        repeat (6) cyc();
        SW_RAW[0] = 1'b0;
        np = 0;
        repeat (30) begin cyc(); if (SW !== 16'h0) np++; end
        chk_eq("s3_glitch_rejected", np, 0);

        // Bouncing button 0, then a steady hold: one press after the hold.
        do_reset();
        np = 0;
        for (int s = 0; s < 10; s++) begin
            BTNS_RAW[0] = (s % 2 == 0);
            repeat (3) begin cyc(); if (BTN_PRESS[0]) np++; end
        end
        chk_eq("s4_no_press_while_bouncing", np, 0);
        BTNS_RAW[0] = 1'b1;
        np2 = 0;
        repeat (30) begin cyc(); if (BTN_PRESS[0]) np2++; end
        chk_eq("s4_single_press", np2, 1);

        // Clear coinciding with a press loses; a clear one cycle later wins.
        BTNS_RAW[0] = 1'b0;
        repeat (20) cyc();
        chk_eq("s5_released", {31'h0, BTNS[0]}, 32'h0);
        CLR_STICKY = 5'b00001;
        cyc();
        CLR_STICKY = '0;
        cyc();
        chk_eq("s5_precleared", {27'h0, BTN_STICKY}, 32'h0);
        BTNS_RAW[0] = 1'b1;
        k = 0;
        do begin cyc(); k++; end while (BTNS[0] !== 1'b1 && k < 20);
        chk_rng("s5_btn_latency", k, 11, 14);
        cyc();
        chk_eq("s5_press", {27'h0, BTN_PRESS}, 32'h1);
        CLR_STICKY = 5'b00001;
        cyc();
        chk_eq("s5_set_wins", {31'h0, BTN_STICKY[0]}, 32'h1);
        cyc();
        chk_eq("s5_clear", {31'h0, BTN_STICKY[0]}, 32'h0);
        CLR_STICKY = '0;

        // Several bits change on the same cycle and accept together.
        do_reset();
        SW_RAW   = 16'hA5C3;
        BTNS_RAW = 5'b10001;
        k = 0;
        do begin cyc(); k++; end while (SW === 16'h0 && BTNS === 5'h0 && k < 20);
        chk_eq("s6_same_cycle", {11'h0, SW, BTNS}, {11'h0, 16'hA5C3, 5'b10001});
        cyc();
        chk_eq("s6_press", {27'h0, BTN_PRESS}, 32'h11);
        cyc();
        chk_eq("s6_sticky", {27'h0, BTN_STICKY}, 32'h11);

        // Random toggling, clears and occasional resets, checked against the model.
        for (int it = 0; it < 150; it++) begin
            hold = $urandom_range(1, 24);
            if ($urandom_range(0, 39) == 0) begin
                RST_N = 1'b0;
                cyc();
                RST_N = 1'b1;
            end
            SW_RAW     = SW_RAW ^ 16'($urandom & $urandom);
            BTNS_RAW   = BTNS_RAW ^ 5'($urandom & $urandom);
            CLR_STICKY = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
            repeat (hold) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
